mem_stage_sequencer: RTL and testbench
======================================

# mem_stage_sequencer

Multi-cycle memory-stage sequencer for the pipelined LC-3b datapath. It sits between the EX/MEM pipeline register and the data-cache port. It sequences word, byte and N-level indirect (LDI/STI-style) accesses over a request/response memory handshake. While an access is in flight it drives the per-stage pipeline enables low, replacing the constant "always enabled" stage enables carried in the decoded control word. Indirection depth and the number of stage enables are parameters.

## Interface
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: data width; must be 16 (two byte lanes).
- `NUM_STAGES`, default 4: number of pipeline-enable outputs (bit 0 = if_id … bit 3 = mem_wb).
- `MAX_INDIRECT`, default 1: maximum pointer dereferences per request; 0 disables indirection.
- `DEPTH_W`, default `$clog2(MAX_INDIRECT+1)` (minimum 1): width of `req_depth`.

Ports:
- `clk` in 1: only clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: EX/MEM holds a memory instruction (`in_mem`).
- `req_st` in 1: 1 = store, 0 = load.
- `req_byte` in 1: byte access (LDB/STB).
- `req_depth` in DEPTH_W: pointer dereferences before the final access (0 = direct).
- `req_addr` in ADDR_W: effective address from ALU/MAR path.
- `req_wdata` in DATA_W: store data.
- `mem_read` out 1: cache read request.
- `mem_write` out 1: cache write request.
- `mem_address` out ADDR_W: cache address.
- `mem_wdata` out DATA_W: cache write data.
- `mem_byte_enable` out 2: lane enables, bit 1 = high byte.
- `mem_rdata` in DATA_W: cache read data, valid with `mem_resp`.
- `mem_resp` in 1: cache completion, one-cycle pulse.
- `rdata` out DATA_W: load result to MEM/WB.
- `rdata_valid` out 1: one-cycle pulse with `rdata` (loads only).
- `done` out 1: one-cycle pulse at completion of every request.
- `busy` out 1: state ≠ IDLE.
- `stage_enable` out NUM_STAGES: pipeline register enables.

## Operation
- States: IDLE, PTR, ACCESS, DONE. The state register, `cnt` (DEPTH_W), `cur_addr`, the latched request fields and `rdata` are all registers.
- **IDLE:**
  - On `req_valid`, latch `req_st`, `req_byte` and `req_wdata`, and set `cur_addr` = `req_addr`.
  - Set `cnt` = min(`req_depth`, `MAX_INDIRECT`).
  - Next state is PTR if `cnt` ≠ 0, otherwise ACCESS.
- **PTR:**
  - Outputs: `mem_read`=1, `mem_address` = {`cur_addr`[ADDR_W-1:1], 0}, `mem_byte_enable`=2'b11.
  - On `mem_resp`: `cur_addr` ← `mem_rdata`, `cnt` ← `cnt`−1. Go to ACCESS when `cnt`==1, otherwise stay in PTR.
- **ACCESS:** `mem_read` = !st, `mem_write` = st.
  - **Word access:** address bit 0 forced to 0; `mem_byte_enable`=2'b11; `mem_wdata` = wdata.
  - **Byte access:** full address presented; `mem_byte_enable` = `cur_addr`[0] ? 2'b10 : 2'b01; `mem_wdata` = {wdata[7:0], wdata[7:0]}.
  - **On `mem_resp` with a load:**
    - Word: `rdata` ← `mem_rdata`.
    - Byte: `rdata` ← zero-extended `mem_rdata`[15:8] if `cur_addr`[0]=1, else zero-extended `mem_rdata`[7:0].
    - Then go to DONE.
- **DONE:**
  - `done`=1; `rdata_valid` = !st.
  - `stage_enable` = all ones, so the pipeline advances past the instruction.
  - Next state is unconditionally IDLE. A `req_valid` seen in DONE belongs to the retiring instruction and is not accepted.
- **Stage enables:** `stage_enable` = all zeros when state is PTR or ACCESS, or when state is IDLE and `req_valid`=1; otherwise all ones.
- **Request latching:** request inputs are ignored outside IDLE.
- **Spurious `mem_resp`:** ignored in IDLE and DONE.
- **`mem_read`/`mem_write`:** decoded from the state register only, never both high. They are held steady until `mem_resp`.
- **`mem_address` outside PTR/ACCESS:** holds `cur_addr`.

## Timing
- **Reset:** asynchronous, and takes effect immediately, including mid-operation. The in-flight access is abandoned, with no retry.
  - State = IDLE, `cnt`=0, `cur_addr`=0, `rdata`=0.
  - `mem_read`=0, `mem_write`=0, `rdata_valid`=0, `done`=0, `busy`=0.
  - `stage_enable` forced all ones while `rst`=1.
- **Latency:** with cache response latency L ≥ 1 cycle (`mem_resp` is never same-cycle), a request of depth d occupies 1 + (d+1)·L + 1 cycles from the IDLE accept to DONE inclusive.
- **Back-to-back requests:** minimum 1 idle cycle between them (the DONE → IDLE transition).

## Test plan
- **Word load:** `req_addr`=0x1003, depth 0, load, L=2, `mem_rdata`=0xBEEF → `mem_address`=0x1002, byte_enable=11, `rdata`=0xBEEF, `rdata_valid` 1 cycle; `stage_enable`=0 for 3 cycles, all ones in DONE.
- **Byte load/store:**
  - LDB at 0x2001 with `mem_rdata`=0xA55A → `rdata`=0x00A5.
  - STB at 0x3000 with `req_wdata`=0x12C4 → `mem_write`, `mem_wdata`=0xC4C4, byte_enable=01, `done` pulse, no `rdata_valid`.
- **Indirect load (MAX_INDIRECT=1):** LDI at 0x4000, depth 1; first response 0x5001, second response 0x7777 → second access address 0x5000, `rdata`=0x7777.
- **Indirect store:** STI depth 1, pointer read returns 0x6000 → write to 0x6000, no `rdata_valid`.
- **Depth chain and saturation (MAX_INDIRECT=2):**
  - Depth 2 → two PTR reads, then the final access.
  - `req_depth`=3 → saturates to 2, with identical bus trace.
- **Reset and spurious response:**
  - `rst` pulsed mid-PTR → `mem_read` drops in the same cycle, `busy`=0, `stage_enable` all ones.
  - `mem_resp` pulsed in IDLE → no state change.

Source files
------------

// File: rtl/mem_stage_sequencer.sv
// Memory-stage sequencer for the pipelined LC-3b: drives the data-cache port for word,
// byte and pointer-chained (LDI/STI) accesses and stalls the pipeline while one is in flight.
module mem_stage_sequencer #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int NUM_STAGES   = 4,
    parameter int MAX_INDIRECT = 1,
    parameter int DEPTH_W      = (MAX_INDIRECT > 0) ? $clog2(MAX_INDIRECT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_st,
    input  logic                  req_byte,
    input  logic [DEPTH_W-1:0]    req_depth,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [1:0]            mem_byte_enable,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  busy,
    output logic [NUM_STAGES-1:0] stage_enable
);
    typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_INDIRECT);

    state_t              state;
    logic [DEPTH_W-1:0]  cnt;
    logic [ADDR_W-1:0]   cur_addr;
    logic                st_q;
    logic                byte_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DEPTH_W-1:0]  depth_sat;

    assign depth_sat = (req_depth > MAX_D) ? MAX_D : req_depth;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_addr <= '0;
            st_q     <= 1'b0;
            byte_q   <= 1'b0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    st_q     <= req_st;
                    byte_q   <= req_byte;
                    wdata_q  <= req_wdata;
                    cur_addr <= req_addr;
                    cnt      <= depth_sat;
                    state    <= (depth_sat != '0) ? PTR : ACCESS;
                end
                PTR: if (mem_resp) begin
                    // the fetched word becomes the address for the next level
                    cur_addr <= ADDR_W'(mem_rdata);
                    cnt      <= cnt - DEPTH_W'(1);
                    if (cnt == DEPTH_W'(1)) state <= ACCESS;
                end
                ACCESS: if (mem_resp) begin
                    if (!st_q) begin
                        if (!byte_q)
                            rdata <= mem_rdata;
                        else if (cur_addr[0])
                            rdata <= {{(DATA_W-8){1'b0}}, mem_rdata[15:8]};
                        else
                            rdata <= {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
                    end
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus controls decode from the state register, so they hold steady until mem_resp.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = cur_addr;
        mem_byte_enable = 2'b11;
        mem_wdata       = wdata_q;
        case (state)
            PTR: begin
                mem_read    = 1'b1;
                mem_address = {cur_addr[ADDR_W-1:1], 1'b0};
            end
            ACCESS: begin
                mem_read  = !st_q;
                mem_write = st_q;
                if (byte_q) begin
                    mem_byte_enable = cur_addr[0] ? 2'b10 : 2'b01;
                    mem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
                end else begin
                    mem_address = {cur_addr[ADDR_W-1:1], 1'b0};
                end
            end
            default: ;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rdata_valid = done && !st_q;

    // Stall from the accept cycle until DONE releases the instruction.
    always_comb begin
        if (rst)
            stage_enable = '1;
        else if (state == PTR || state == ACCESS || (state == IDLE && req_valid))
            stage_enable = '0;
        else
            stage_enable = '1;
    end
endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed bench for mem_stage_sequencer: vector table of accesses against a small
// latency-programmable cache model, plus hand sequences for reset and stray responses.
module tb_mem_stage_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_st, req_byte;
    logic [1:0]  req_depth;
    logic [15:0] req_addr, req_wdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] rdata;
    logic        rdata_valid, done, busy;
    logic [3:0]  stage_enable;

    logic        resp_m = 1'b0;
    logic        spur = 1'b0;
    int          lat = 1;
    int          wcnt = 0;
    logic [35:0] trace[$];
    int          checks = 0;
    int          errors = 0;

    assign mem_resp = resp_m | spur;

    mem_stage_sequencer #(.ADDR_W(16), .DATA_W(16), .NUM_STAGES(4), .MAX_INDIRECT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_st(req_st), .req_byte(req_byte),
        .req_depth(req_depth), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
        .busy(busy), .stage_enable(stage_enable)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case ({a[15:1], 1'b0})
            16'h1002: mem_model = 16'hBEEF;
            16'h2000: mem_model = 16'hA55A;
            16'h4000: mem_model = 16'h5001;
            16'h5000: mem_model = 16'h7777;
            16'h6100: mem_model = 16'h6000;
            16'h7000: mem_model = 16'h7101;
            16'h7100: mem_model = 16'h8003;
            16'h8002: mem_model = 16'h1234;
            default:  mem_model = 16'h0000;
        endcase
    endfunction

    // Cache model: answers lat cycles after a request appears; logs each completed access.
    always @(negedge clk) begin
        if (rst || !(mem_read || mem_write)) begin
            wcnt   = 0;
            resp_m = 1'b0;
        end else begin
            wcnt = wcnt + 1;
            if (wcnt >= lat) begin
                resp_m    = 1'b1;
                wcnt      = 0;
                mem_rdata = mem_model(mem_address);
                trace.push_back({mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata});
            end else begin
                resp_m = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic        byt;
        logic [1:0]  depth;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
        logic        e_rv;
        int          e_cycles;
        int          e_acc;
    } vec_t;

    vec_t vecs[10];
    int   bases[10];

    task automatic run(input vec_t v, input bit poke);
        int base, n, zeros;
        bit seen;
        logic [35:0] last;
        lat  = v.lat;
        base = trace.size();
        @(negedge clk);
        req_st = v.st; req_byte = v.byt; req_depth = v.depth;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        #1;
        zeros = (stage_enable == 4'h0) ? 1 : 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else if (stage_enable == 4'h0) zeros++;
        end
        chk("done_seen", 36'(seen), 36'd1);
        chk("cycles", 36'(1 + n), 36'(v.e_cycles));
        chk("stall_cycles", 36'(zeros), 36'(v.e_cycles - 1));
        chk("done_stage_en", 36'(stage_enable), 36'hF);
        chk("rdata_valid", 36'(rdata_valid), 36'(v.e_rv));
        chk("rdata", 36'(rdata), 36'(v.e_rdata));
        chk("access_count", 36'(trace.size() - base), 36'(v.e_acc));
        if (trace.size() > base) begin
            last = trace[trace.size() - 1];
            chk("rd_wr", 36'(last[35:34]), 36'({!v.st, v.st}));
            chk("addr", 36'(last[33:18]), 36'(v.e_addr));
            chk("byte_en", 36'(last[17:16]), 36'(v.e_be));
            if (v.st) chk("wdata", 36'(last[15:0]), 36'(v.e_wdata));
            if (v.depth != 0)
                chk("ptr_addr", 36'(trace[base][35:16]), 36'({2'b10, v.addr[15:1], 1'b0, 2'b11}));
        end
        if (poke) begin
            req_st = 1'b0; req_byte = 1'b0; req_depth = 2'd0; req_addr = 16'h1002;
            req_valid = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("done_pulse", 36'(done), 36'd0);
        chk("idle_after", 36'(busy), 36'd0);
    endtask

    initial begin
        logic [15:0] r_hold;
        //          st   byt  d     addr      wdata    L  e_addr    be     e_wdata   e_rdata   rv  cyc acc
        vecs[0] = '{1'b0, 1'b0, 2'd0, 16'h1003, 16'h0000, 2, 16'h1002, 2'b11, 16'h0000, 16'hBEEF, 1'b1, 4, 1};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 16'h2001, 16'h0000, 1, 16'h2001, 2'b10, 16'h0000, 16'h00A5, 1'b1, 3, 1};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 16'h2000, 16'h0000, 3, 16'h2000, 2'b01, 16'h0000, 16'h005A, 1'b1, 5, 1};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 16'h3000, 16'h12C4, 2, 16'h3000, 2'b01, 16'hC4C4, 16'h005A, 1'b0, 4, 1};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 16'h4000, 16'h0000, 2, 16'h5000, 2'b11, 16'h0000, 16'h7777, 1'b1, 6, 2};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 16'h6100, 16'hCAFE, 1, 16'h6000, 2'b11, 16'hCAFE, 16'h7777, 1'b0, 4, 2};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 16'h3005, 16'h55AA, 1, 16'h3004, 2'b11, 16'h55AA, 16'h7777, 1'b0, 3, 1};
        vecs[7] = '{1'b0, 1'b0, 2'd2, 16'h7000, 16'h0000, 2, 16'h8002, 2'b11, 16'h0000, 16'h1234, 1'b1, 8, 3};
        vecs[8] = '{1'b0, 1'b0, 2'd3, 16'h7000, 16'h0000, 2, 16'h8002, 2'b11, 16'h0000, 16'h1234, 1'b1, 8, 3};
        vecs[9] = '{1'b0, 1'b1, 2'd1, 16'h4000, 16'h0000, 1, 16'h5001, 2'b10, 16'h0000, 16'h0077, 1'b1, 4, 2};

        rst = 1'b1; req_valid = 1'b1; req_st = 1'b0; req_byte = 1'b0; req_depth = 2'd0;
        req_addr = 16'h0; req_wdata = 16'h0; mem_rdata = 16'h0;
        @(negedge clk); #1;
        chk("rst_stage_en", 36'(stage_enable), 36'hF);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_rd_wr", 36'({mem_read, mem_write}), 36'd0);
        chk("rst_done_rv", 36'({done, rdata_valid}), 36'd0);
        chk("rst_rdata", 36'(rdata), 36'd0);
        chk("rst_addr", 36'(mem_address), 36'd0);
        chk("idle_stage_en", 36'(stage_enable), 36'hF);

        for (int i = 0; i < 10; i++) begin
            bases[i] = trace.size();
            run(vecs[i], i == 6);
        end
        for (int i = 0; i < 3; i++)
            chk("sat_trace", trace[bases[8] + i], trace[bases[7] + i]);

        // Stray response while idle must not start anything or touch rdata.
        r_hold = rdata;
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        #1;
        chk("spur_busy", 36'(busy), 36'd0);
        chk("spur_done", 36'(done), 36'd0);
        chk("spur_rdata", 36'(rdata), 36'(r_hold));

        // Reset landing in the middle of a pointer fetch.
        lat = 4;
        @(negedge clk);
        req_st = 1'b0; req_byte = 1'b0; req_depth = 2'd1; req_addr = 16'h4000; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); #1;
        chk("ptr_read", 36'({mem_read, busy}), 36'b11);
        rst = 1'b1;
        #1;
        chk("midrst_read", 36'(mem_read), 36'd0);
        chk("midrst_busy", 36'(busy), 36'd0);
        chk("midrst_stage_en", 36'(stage_enable), 36'hF);
        chk("midrst_rdata", 36'(rdata), 36'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_busy", 36'(busy), 36'd0);
        run(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
